// File: rtl/booth_r4_seq_multiplier_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier.
package booth_r4_seq_multiplier_pkg;

  // Operand signedness selector; the remaining code 2'b11 behaves as MODE_UU.
  typedef enum logic [1:0] {
    MODE_UU = 2'b00,
    MODE_SS = 2'b01,
    MODE_SU = 2'b10
  } booth_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } booth_fsm_e;

  // Recoded Booth digit: magnitude one or two, optionally negated.
  // All fields clear means the digit is zero.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_op_t;

  // The multiplicand (rs1) is signed in both signed modes.
  function automatic logic mcand_is_signed(input logic [1:0] mode);
    return (mode == MODE_SS) || (mode == MODE_SU);
  endfunction

  // The multiplier (rs2) is signed only in signed x signed mode.
  function automatic logic mplier_is_signed(input logic [1:0] mode);
    return (mode == MODE_SS);
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: overlapping 3-bit multiplier group -> digit.
module booth_r4_encoder
  import booth_r4_seq_multiplier_pkg::*;
(
  input  logic [2:0] group,
  output booth_op_t  op
);

  // 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1
  assign op.neg = group[2] & ~(group[1] & group[0]);
  assign op.one = group[1] ^ group[0];
  assign op.two = (group == 3'b011) || (group == 3'b100);

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Valid/ready on both sides, clock enable, synchronous flush.
// Optional macro MGT01_BOOTH_ZERO_SKIP_EN: a zero operand finishes at once.
module booth_r4_seq_multiplier
  import booth_r4_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clk_en_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [1:0]           mode_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int STEPS = WIDTH / 2 + 1;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int AW    = WIDTH + 2;       // extended operand width
  localparam int PW    = WIDTH + 3;       // accumulator width, holds +-2B

  booth_fsm_e       state_q, state_d;
  logic [PW-1:0]    p_q;
  logic [AW-1:0]    a_q;                  // multiplier, shifted out 2 bits per step
  logic             l_q;                  // bit shifted out below a_q[0]
  logic [AW-1:0]    mcand_q;
  logic [CNT_W-1:0] cnt_q;

  logic [AW-1:0]    mcand_ext, mplier_ext;
  logic             zero_ops;
  logic             last_step;
  booth_op_t        op;
  logic [PW-1:0]    pp_mag, pp, sum;
  logic [PW+AW:0]   shifted;

  assign mcand_ext  = {{2{a_i[WIDTH-1] & mcand_is_signed(mode_i)}}, a_i};
  assign mplier_ext = {{2{b_i[WIDTH-1] & mplier_is_signed(mode_i)}}, b_i};
  assign last_step  = (cnt_q == CNT_W'(STEPS - 1));

`ifdef MGT01_BOOTH_ZERO_SKIP_EN
  assign zero_ops = (a_i == '0) || (b_i == '0);
`else
  assign zero_ops = 1'b0;
`endif

  booth_r4_encoder u_enc (
    .group ({a_q[1:0], l_q}),
    .op    (op)
  );

  // One Booth step: add the selected partial product, then shift {P,A,L} right by 2.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    pp_mag = '0;
    if (op.two)
      pp_mag = {mcand_q, 1'b0};
    else if (op.one)
      pp_mag = {mcand_q[AW-1], mcand_q};
    pp      = op.neg ? -pp_mag : pp_mag;
    sum     = p_q + pp;
    shifted = $signed({sum, a_q, l_q}) >>> 2;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i)   state_d = zero_ops ? DONE : MUL;
      MUL:     if (last_step) state_d = DONE;
      DONE:    if (ready_i)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // State register, frozen while the clock enable is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i)
      state_q <= IDLE;
    else if (clk_en_i)
      state_q <= state_d;
  end

  // Datapath: load operands on accept, iterate in MUL, clear on flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: datapath registers are reset too, because result_o is read straight from them.
    if (rst_i) begin
      p_q     <= '0;
      a_q     <= '0;
      l_q     <= 1'b0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else if (clk_en_i) begin
      if (flush_i) begin
        p_q     <= '0;
        a_q     <= '0;
        l_q     <= 1'b0;
        mcand_q <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (valid_i) begin
              mcand_q <= mcand_ext;
              a_q     <= zero_ops ? '0 : mplier_ext;
              p_q     <= '0;
              l_q     <= 1'b0;
              cnt_q   <= '0;
            end
          end
          MUL: begin
            {p_q, a_q, l_q} <= shifted;
            cnt_q           <= cnt_q + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = {p_q[WIDTH-3:0], a_q};

endmodule
